// File: rtl/conv_pe_pipe.sv
// -----------------------------------------------------------------------------
// conv_pe_pipe
// Convolution processing element for the LeNet-5 datapath. It computes TAPS
// parallel products of unsigned feature pixels and signed weights, adds them
// to an incoming partial sum, then applies optional ReLU and optional 8-bit
// requantisation. The pipeline is elastic and has three register stages:
//   S1 multiply -> S2 adder-tree reduce -> S3 post-process into pe_out.
// Each stage advances when it is empty or when the stage after it advances,
// so a full pipeline can accept a new input and drain an output in the same
// cycle.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_if               TAPS packed unsigned pixels, tap k at [k*IF_W +: IF_W]
//   in_w                TAPS packed signed weights, tap k at [k*W_W +: W_W]
//   psum                signed partial sum / bias
//   relu_en, quan_en    per-transaction post-process enables
//   out_valid/out_ready output handshake
//   pe_out              result; a requantised result is zero-extended Q_W bits
//   sat_clr, sat_cnt    only with CONV_PE_SAT_CNT_EN: a 16-bit saturating
//                       count of clipped requantised results, with sync clear
//
// Optional build macro: CONV_PE_SAT_CNT_EN
// Assumes QSHIFT >= 1, Q_W < ACC_W and ACC_W > IF_W+W_W+1.
// -----------------------------------------------------------------------------
module conv_pe_pipe #(
  parameter int TAPS   = 25,
  parameter int IF_W   = 8,
  parameter int W_W    = 8,
  parameter int ACC_W  = 32,
  parameter int QSHIFT = 7,
  parameter int Q_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CONV_PE_SAT_CNT_EN
  input  logic                    sat_clr,
  output logic [15:0]             sat_cnt,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TAPS*IF_W-1:0]    in_if,
  input  logic [TAPS*W_W-1:0]     in_w,
  input  logic [ACC_W-1:0]        psum,
  input  logic                    relu_en,
  input  logic                    quan_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        pe_out
);

  // Product width: a 9-bit signed pixel times an 8-bit signed weight
  localparam int PW = IF_W + W_W + 1;
  localparam logic [ACC_W-1:0] QMAX = ACC_W'((64'd1 << Q_W) - 64'd1);

  // Pipeline state
  logic                   s1_valid_q;
  logic signed [PW-1:0]   s1_prod_q [TAPS];
  logic [ACC_W-1:0]       s1_psum_q;
  logic                   s1_relu_q;
  logic                   s1_quan_q;

  logic                   s2_valid_q;
  logic [ACC_W-1:0]       s2_sum_q;
  logic                   s2_relu_q;
  logic                   s2_quan_q;

  logic                   out_valid_q;
  logic [ACC_W-1:0]       pe_out_q;

  // Next-state values and stage advance enables
  logic signed [PW-1:0]   s1_prod_d [TAPS];
  logic [ACC_W-1:0]       s2_sum_d;
  logic [ACC_W:0]         post_res_d;   // {clip flag, value}
  logic                   adv1, adv2, adv3;

  // Advance enables ripple backwards from the output
  assign adv3     = !out_valid_q || out_ready;
  assign adv2     = !s2_valid_q  || adv3;
  assign adv1     = !s1_valid_q  || adv2;
  assign in_ready = adv1;

  assign out_valid = out_valid_q;
  assign pe_out    = pe_out_q;

  // ReLU plus requantisation. Bit ACC_W of the result reports a clip:
  // either a negative value clamped to 0, or a value clipped to QMAX
  // (including when round-half-up overflows QMAX).
  function automatic logic [ACC_W:0] post_proc(input logic [ACC_W-1:0] sum,
                                               input logic relu,
                                               input logic quan);
    logic [ACC_W-1:0] r;
    logic [ACC_W-1:0] q;
    logic [ACC_W-1:0] val;
    logic             clip;
    if (relu && sum[ACC_W-1]) begin
      r = {ACC_W{1'b0}};
    end else begin
      r = sum;
    end
    clip = 1'b0;
    q    = {ACC_W{1'b0}};
    if (!quan) begin
      val = r;
    end else if (r[ACC_W-1]) begin
      val  = {ACC_W{1'b0}};
      clip = 1'b1;
    end else begin
      // r is non-negative here, so a logical shift matches >>>
      q = r >> QSHIFT;
      if (q > QMAX) begin
        val  = QMAX;
        clip = 1'b1;
      end else begin
        q = q + {{(ACC_W-1){1'b0}}, r[QSHIFT-1]};
        if (q > QMAX) begin
          val  = QMAX;
          clip = 1'b1;
        end else begin
          val = q;
        end
      end
    end
    return {clip, val};
  endfunction

  // Per-tap multiplier: the pixel is zero-extended and the weight is
  // sign-extended to PW bits, so the signed product is exact in PW bits.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic signed [PW-1:0] pix_ext;
    logic signed [PW-1:0] w_ext;
    assign pix_ext      = signed'({{(PW-IF_W){1'b0}}, in_if[k*IF_W +: IF_W]});
    assign w_ext        = signed'({{(PW-W_W){in_w[k*W_W+W_W-1]}}, in_w[k*W_W +: W_W]});
    assign s1_prod_d[k] = pix_ext * w_ext;
  end

  // Adder tree: psum plus every sign-extended product, wrapping at ACC_W
  always_comb begin
    s2_sum_d = s1_psum_q;
    for (int k = 0; k < TAPS; k++) begin
      s2_sum_d = s2_sum_d + {{(ACC_W-PW){s1_prod_q[k][PW-1]}}, s1_prod_q[k]};
    end
  end

  // Post-process applied to the S2 contents
  always_comb begin
    post_res_d = post_proc(s2_sum_q, s2_relu_q, s2_quan_q);
  end

  // Stage 1: capture products and per-transaction controls on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_psum_q  <= {ACC_W{1'b0}};
      s1_relu_q  <= 1'b0;
      s1_quan_q  <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        s1_prod_q[k] <= {PW{1'b0}};
      end
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_psum_q <= psum;
        s1_relu_q <= relu_en;
        s1_quan_q <= quan_en;
        for (int k = 0; k < TAPS; k++) begin
          s1_prod_q[k] <= s1_prod_d[k];
        end
      end
    end
  end

  // Stage 2: register the reduced sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= {ACC_W{1'b0}};
      s2_relu_q  <= 1'b0;
      s2_quan_q  <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_q  <= s2_sum_d;
        s2_relu_q <= s1_relu_q;
        s2_quan_q <= s1_quan_q;
      end
    end
  end

  // Stage 3: register the post-processed result; held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      pe_out_q    <= {ACC_W{1'b0}};
    end else if (adv3) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        pe_out_q <= post_res_d[ACC_W-1:0];
      end
    end
  end

`ifdef CONV_PE_SAT_CNT_EN
  logic [15:0] sat_cnt_q;

  assign sat_cnt = sat_cnt_q;

  // Saturation counter: counts clipped S3 loads, sticks at all-ones, clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= 16'h0000;
    end else if (sat_clr) begin
      sat_cnt_q <= 16'h0000;
    end else if (adv3 && s2_valid_q && post_res_d[ACC_W] && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'h0001;
    end
  end
`else
  logic unused_clip;
  assign unused_clip = post_res_d[ACC_W];
`endif

endmodule
